// File: rtl/direct_pkg.sv
// Shared constants and types for the direct 12-bit codeword decoder.
// Codeword layout is {payload[7:0], marker[3:0]}.
package direct_pkg;

    localparam int CW_WIDTH     = 12;
    localparam int DATA_WIDTH   = 8;
    localparam int MARKER_WIDTH = 4;
    localparam logic [MARKER_WIDTH-1:0] MARKER = 4'b1010;

    typedef enum logic {
        SYNC_SEARCH = 1'b0,
        SYNC_LOCKED = 1'b1
    } sync_state_t;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/direct_dec_sync_fsm.sv
// Marker-lock tracker: consecutive good markers lock, consecutive bad markers unlock.
// Advances only on accepted words; locked is the registered state.
module direct_dec_sync_fsm
    import direct_pkg::*;
#(
    parameter int LOCK_COUNT   = 3,
    parameter int UNLOCK_COUNT = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic accept,
    input  logic bad_marker,
    output logic locked
);

    localparam int CNT_W = $clog2(max_int(LOCK_COUNT, UNLOCK_COUNT) + 1);
    localparam logic [CNT_W-1:0] LOCK_N   = CNT_W'(LOCK_COUNT);
    localparam logic [CNT_W-1:0] UNLOCK_N = CNT_W'(UNLOCK_COUNT);

    sync_state_t      state, state_next;
    logic [CNT_W-1:0] good_cnt, good_next;
    logic [CNT_W-1:0] bad_cnt, bad_next;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= SYNC_SEARCH;
            good_cnt <= '0;
            bad_cnt  <= '0;
        end else begin
            state    <= state_next;
            good_cnt <= good_next;
            bad_cnt  <= bad_next;
        end
    end

    always_comb begin
        state_next = state;
        good_next  = good_cnt;
        bad_next   = bad_cnt;
        if (accept) begin
            case (state)
                SYNC_SEARCH: begin
                    if (bad_marker) begin
                        good_next = '0;
                    end else if (good_cnt + CNT_W'(1) == LOCK_N) begin
                        state_next = SYNC_LOCKED;
                        good_next  = '0;
                        bad_next   = '0;
                    end else begin
                        good_next = good_cnt + CNT_W'(1);
                    end
                end
                SYNC_LOCKED: begin
                    if (!bad_marker) begin
                        bad_next = '0;
                    end else if (bad_cnt + CNT_W'(1) == UNLOCK_N) begin
                        state_next = SYNC_SEARCH;
                        good_next  = '0;
                        bad_next   = '0;
                    end else begin
                        bad_next = bad_cnt + CNT_W'(1);
                    end
                end
                default: state_next = SYNC_SEARCH;
            endcase
        end
    end

    assign locked = (state == SYNC_LOCKED);

endmodule

// File: rtl/direct_decoder.sv
// Direct codeword decoder: strips the marker, flags bad markers, tracks lock.
// Optional saturating marker-error counter enabled by DIRECT_DEC_ERR_CNT_EN.
module direct_decoder
    import direct_pkg::*;
#(
    parameter int DATA_WIDTH    = direct_pkg::DATA_WIDTH,
    parameter int MARKER_WIDTH  = direct_pkg::MARKER_WIDTH,
    parameter logic [MARKER_WIDTH-1:0] MARKER = direct_pkg::MARKER,
    parameter int LOCK_COUNT    = 3,
    parameter int UNLOCK_COUNT  = 2,
    parameter int ERR_CNT_WIDTH = 16
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic                             in_valid,
    output logic                             in_ready,
    input  logic [DATA_WIDTH+MARKER_WIDTH-1:0] in_codeword,
    output logic                             out_valid,
    input  logic                             out_ready,
    output logic [DATA_WIDTH-1:0]            out_data,
    output logic                             out_marker_err,
`ifdef DIRECT_DEC_ERR_CNT_EN
    output logic [ERR_CNT_WIDTH-1:0]         err_count,
`endif
    output logic                             locked
);

    if (LOCK_COUNT < 1 || UNLOCK_COUNT < 1 || ERR_CNT_WIDTH < 1) begin : g_bad_params
        $error("direct_decoder: LOCK_COUNT, UNLOCK_COUNT and ERR_CNT_WIDTH must be >= 1");
    end

    logic accept;
    logic bad_marker;

    assign in_ready   = !out_valid || out_ready;
    assign accept     = in_valid && in_ready;
    assign bad_marker = (in_codeword[MARKER_WIDTH-1:0] != MARKER);

    // Single output register; in_ready lets it reload on the transfer cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid      <= 1'b0;
            out_data       <= '0;
            out_marker_err <= 1'b0;
        end else if (accept) begin
            out_valid      <= 1'b1;
            out_data       <= in_codeword[DATA_WIDTH+MARKER_WIDTH-1:MARKER_WIDTH];
            out_marker_err <= bad_marker;
        end else if (out_ready) begin
            out_valid      <= 1'b0;
        end
    end

    direct_dec_sync_fsm #(
        .LOCK_COUNT   (LOCK_COUNT),
        .UNLOCK_COUNT (UNLOCK_COUNT)
    ) u_sync (
        .clk        (clk),
        .rst_n      (rst_n),
        .accept     (accept),
        .bad_marker (bad_marker),
        .locked     (locked)
    );

`ifdef DIRECT_DEC_ERR_CNT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_count <= '0;
        end else if (accept && bad_marker && (err_count != '1)) begin
            err_count <= err_count + ERR_CNT_WIDTH'(1);
        end
    end
`endif

endmodule

// File: tb/tb_direct_decoder.sv
// Directed self-checking bench for direct_decoder (builds with or without
// DIRECT_DEC_ERR_CNT_EN; error-counter checks only when the port exists).
module tb_direct_decoder;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [11:0] in_codeword;
    logic        out_valid;
    logic        out_ready;
    logic [7:0]  out_data;
    logic        out_marker_err;
    logic        locked;
`ifdef DIRECT_DEC_ERR_CNT_EN
    logic [1:0]  err_count;
`endif

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    direct_decoder #(
        .LOCK_COUNT    (3),
        .UNLOCK_COUNT  (2),
        .ERR_CNT_WIDTH (2)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .in_valid       (in_valid),
        .in_ready       (in_ready),
        .in_codeword    (in_codeword),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_data       (out_data),
        .out_marker_err (out_marker_err),
`ifdef DIRECT_DEC_ERR_CNT_EN
        .err_count      (err_count),
`endif
        .locked         (locked)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // One accepted word with out_ready=1, then check the output register.
    task automatic send(input logic [11:0] cw, input logic exp_err, input logic exp_lock);
        in_valid    = 1'b1;
        in_codeword = cw;
        out_ready   = 1'b1;
        cyc();
        chk($sformatf("valid_%03h", cw), 32'(out_valid), 32'd1);
        chk($sformatf("data_%03h", cw), 32'(out_data), 32'(cw[11:4]));
        chk($sformatf("merr_%03h", cw), 32'(out_marker_err), 32'(exp_err));
        chk($sformatf("lock_%03h", cw), 32'(locked), 32'(exp_lock));
    endtask

    task automatic do_reset();
        rst_n       = 1'b0;
        in_valid    = 1'b0;
        in_codeword = '0;
        out_ready   = 1'b0;
        repeat (2) cyc();
        rst_n = 1'b1;
        cyc();
    endtask

    initial begin
        do_reset();
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_data", 32'(out_data), 32'd0);
        chk("rst_merr", 32'(out_marker_err), 32'd0);
        chk("rst_locked", 32'(locked), 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd1);
`ifdef DIRECT_DEC_ERR_CNT_EN
        chk("rst_err_count", 32'(err_count), 32'd0);
`endif

        // Lock acquisition: third good marker locks on its accept edge.
        send(12'hAAA, 1'b0, 1'b0);
        send(12'h55A, 1'b0, 1'b0);
        send(12'hFFA, 1'b0, 1'b1);

        // Single bad then good clears bad_cnt; two consecutive bads unlock.
        send(12'h120, 1'b1, 1'b1);
`ifdef DIRECT_DEC_ERR_CNT_EN
        chk("errcnt_a", 32'(err_count), 32'd1);
`endif
        send(12'h12A, 1'b0, 1'b1);
        send(12'h3C0, 1'b1, 1'b1);
        send(12'h3C5, 1'b1, 1'b0);
`ifdef DIRECT_DEC_ERR_CNT_EN
        chk("errcnt_b", 32'(err_count), 32'd3);
`endif

        // Drain, then backpressure.
        in_valid  = 1'b0;
        out_ready = 1'b1;
        cyc();
        chk("drain_valid", 32'(out_valid), 32'd0);

        in_valid    = 1'b1;
        in_codeword = 12'h77A;
        out_ready   = 1'b0;
        cyc();
        chk("bp_first_data", 32'(out_data), 32'h77);
        in_codeword = 12'h81A;
        for (int i = 0; i < 4; i++) begin
            chk("bp_in_ready", 32'(in_ready), 32'd0);
            chk("bp_hold_data", 32'(out_data), 32'h77);
            chk("bp_hold_valid", 32'(out_valid), 32'd1);
            cyc();
        end
        out_ready = 1'b1;
        #1;
        chk("bp_release_ready", 32'(in_ready), 32'd1);
        cyc();
        chk("bp_reload_data", 32'(out_data), 32'h81);
        chk("bp_reload_valid", 32'(out_valid), 32'd1);
        chk("bp_locked", 32'(locked), 32'd0);

        // Alternating markers in SEARCH never lock.
        for (int i = 0; i < 6; i++) begin
            if (i % 2 == 0) begin
                send(12'h120, 1'b1, 1'b0);
                chk("alt_good_cnt_bad", 32'(dut.u_sync.good_cnt), 32'd0);
            end else begin
                send(12'hAAA, 1'b0, 1'b0);
                chk("alt_good_cnt_good", 32'(dut.u_sync.good_cnt), 32'd1);
            end
        end

        // Five bad words after reset: counter saturates at 3 for width 2.
        do_reset();
        send(12'h011, 1'b1, 1'b0);
`ifdef DIRECT_DEC_ERR_CNT_EN
        chk("sat_1", 32'(err_count), 32'd1);
`endif
        send(12'h022, 1'b1, 1'b0);
`ifdef DIRECT_DEC_ERR_CNT_EN
        chk("sat_2", 32'(err_count), 32'd2);
`endif
        send(12'h033, 1'b1, 1'b0);
`ifdef DIRECT_DEC_ERR_CNT_EN
        chk("sat_3", 32'(err_count), 32'd3);
`endif
        send(12'h044, 1'b1, 1'b0);
`ifdef DIRECT_DEC_ERR_CNT_EN
        chk("sat_4", 32'(err_count), 32'd3);
`endif
        send(12'h055, 1'b1, 1'b0);
`ifdef DIRECT_DEC_ERR_CNT_EN
        chk("sat_5", 32'(err_count), 32'd3);
`endif

        // Asynchronous reset with a pending word while locked.
        send(12'hAAA, 1'b0, 1'b0);
        send(12'hBBA, 1'b0, 1'b0);
        send(12'hCCA, 1'b0, 1'b1);
        in_valid  = 1'b0;
        out_ready = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_out_valid", 32'(out_valid), 32'd0);
        chk("async_locked", 32'(locked), 32'd0);
        chk("async_out_data", 32'(out_data), 32'd0);
`ifdef DIRECT_DEC_ERR_CNT_EN
        chk("async_err_count", 32'(err_count), 32'd0);
`endif
        cyc();
        rst_n = 1'b1;
        cyc();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
